// File: rtl/ble_tx_seq_pkg.sv
// ble_tx_seq_pkg: state encoding and shared widths for the BLE TX sequencer
package ble_tx_seq_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_GAP  = 3'd2;
    localparam state_t ST_PLD  = 3'd3;
    localparam state_t ST_WAIT = 3'd4;
    localparam state_t ST_DONE = 3'd5;
    localparam state_t ST_ERR  = 3'd6;
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ble_tx_byte_fifo.sv
// ble_tx_byte_fifo: first-word fall-through byte FIFO with flush
module ble_tx_byte_fifo import ble_tx_seq_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [BYTE_W-1:0]         wdata,
    output logic [BYTE_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign rdata   = mem[rp];
    assign do_pop  = pop && !empty;
    // a pop frees the slot this cycle, so a push while full still lands
    assign do_push = push && (!full || do_pop) && !flush;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/ble_tx_sequencer.sv
// ble_tx_sequencer: header/gap/payload serializer for the BLE PHY TX chain; BLE_TX_SEQ_TIMEOUT_EN adds a done-pulse timeout
module ble_tx_sequencer import ble_tx_seq_pkg::*; #(
    parameter int HEADER_BITS    = 18,
    parameter int FIFO_DEPTH     = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CNT_W-1:0]               payload_size,
    input  logic                           wr_en,
    input  logic [BYTE_W-1:0]              wr_data,
    output logic                           fifo_full,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           tx_valid_in,
    output logic                           tx_data_in,
    input  logic                           tx_done_pulse,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);
    if (HEADER_BITS < 1 || HEADER_BITS > 64 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("ble_tx_sequencer: illegal parameter value");
    end
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, psize;
    logic [2:0] bit_idx;
    logic [BYTE_W-1:0] head;
    logic empty, pop, flush, serial, underflow, last, shift, accept, reject;
    ble_tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .flush(flush), .push(wr_en), .pop(pop),
        .wdata(wr_data), .rdata(head), .full(fifo_full), .empty(empty), .level(fifo_level)
    );
    always_ff @(posedge clk)
        state <= reset ? ST_IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: nxt = accept ? ST_HDR : ST_IDLE;
            ST_HDR:  nxt = underflow ? ST_ERR : last ? ST_GAP : ST_HDR;
            ST_GAP:  nxt = (cnt == CNT_W'(GAP_CYCLES - 1)) ? ST_PLD : ST_GAP;
            ST_PLD:  nxt = underflow ? ST_ERR : last ? ST_WAIT : ST_PLD;
`ifdef BLE_TX_SEQ_TIMEOUT_EN
            ST_WAIT: nxt = tx_done_pulse ? ST_DONE : (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) ? ST_ERR : ST_WAIT;
`else
            ST_WAIT: nxt = tx_done_pulse ? ST_DONE : ST_WAIT;
`endif
            default: nxt = ST_IDLE;
        endcase
    end
    always_comb begin
        busy      = state != ST_IDLE;
        done      = state == ST_DONE;
        flush     = state == ST_ERR;
        accept    = state == ST_IDLE && start && payload_size != '0;
        reject    = state == ST_IDLE && start && payload_size == '0;
        serial    = state == ST_HDR || state == ST_PLD;
        underflow = serial && bit_idx == 3'd0 && empty;
        last      = state == ST_HDR ? cnt == CNT_W'(HEADER_BITS - 1) : cnt == psize - CNT_W'(1);
        shift     = serial && !underflow;
        pop       = shift && (bit_idx == 3'd7 || last);
    end
    // cnt restarts on every state change: bits in HDR/PLD, idle cycles in GAP/WAIT_DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            psize       <= '0;
            bit_idx     <= '0;
            error       <= 1'b0;
            tx_valid_in <= 1'b0;
            tx_data_in  <= 1'b0;
        end else begin
            cnt         <= (nxt != state) ? '0 : cnt + CNT_W'(1);
            psize       <= accept ? payload_size : psize;
            bit_idx     <= shift ? (last ? 3'd0 : bit_idx + 3'd1) : bit_idx;
            error       <= accept ? 1'b0 : (reject || flush) ? 1'b1 : error;
            tx_valid_in <= shift;
            tx_data_in  <= shift && head[bit_idx];
        end
    end
endmodule
